alt_mge_phy_reconfig_rmw_seq: RTL and testbench

- Multi-profile, multi-channel PHY reconfiguration sequencer. It replaces per-profile fixed parameter packages with a runtime-selected profile.
- Walks a profile ROM of DPRIO entries. Each entry is 26 bits: [25:16] address, [15:8] bit mask, [7:0] value.
- For each entry it performs an Avalon-MM read-modify-write on one selected channel, or broadcasts to all channels.
- Sits between the rate-switch controller and the transceiver reconfig interface.

---
 rtl/alt_mge_phy_reconfig_rmw_seq.sv | 217 +++++++++++++++++++++
 tb/tb_alt_mge_phy_reconfig_rmw_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_mge_phy_reconfig_rmw_seq.sv
// Profile-driven DPRIO read-modify-write sequencer between the rate-switch
// controller and the transceiver reconfig port; one channel or broadcast.
module alt_mge_phy_reconfig_rmw_seq #(
    parameter int NUM_CHANNELS   = 4,
    parameter int NUM_PROFILES   = 4,
    parameter int RAM_DEPTH      = 7,
    parameter int CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int PROF_W         = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
    parameter int ROM_AW         = (NUM_PROFILES * RAM_DEPTH > 1) ?
                                   $clog2(NUM_PROFILES * RAM_DEPTH) : 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PROF_W-1:0] profile_sel,
    input  logic [CH_W-1:0]   chan_sel,
    input  logic              chan_all,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rom_rd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [25:0]       rom_data,
    output logic [CH_W+10:0]  reconfig_address,
    output logic              reconfig_read,
    output logic              reconfig_write,
    output logic [31:0]       reconfig_writedata,
    input  logic [31:0]       reconfig_readdata,
    input  logic              reconfig_waitrequest
);

    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_REQ,
        S_ROM_WAIT,
        S_DECODE,
        S_AV_RD,
        S_AV_WR,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [PROF_W-1:0]   prof_q;
    logic [CH_W-1:0]     chan_q;
    logic                all_q;
    logic [IDX_W-1:0]    idx_q;
    logic [25:0]         entry_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                rom_rd_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic [CH_W+10:0]    addr_q;
    logic                rd_q;
    logic                wr_q;
    logic [7:0]          wdata_q;

    logic [7:0]          mask;
    logic [7:0]          value;
    logic [7:0]          merge_d;
    logic [IDX_W-1:0]    idx_d;
    logic                prof_bad;
    logic                tmo_hit;
    logic                unused_rdata;

    function automatic logic [ROM_AW-1:0] rom_ptr(
        input logic [PROF_W-1:0] p,
        input logic [IDX_W-1:0]  i
    );
        return ROM_AW'(32'(p) * 32'(RAM_DEPTH) + 32'(i));
    endfunction

    assign mask         = entry_q[15:8];
    assign value        = entry_q[7:0];
    assign merge_d      = (reconfig_readdata[7:0] & ~mask) | (value & mask);
    assign idx_d        = idx_q + 1'b1;
    assign prof_bad     = 32'(profile_sel) >= 32'(NUM_PROFILES);
    assign tmo_hit      = tmo_q == TMO_LAST;
    assign unused_rdata = ^reconfig_readdata[31:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prof_q     <= '0;
            chan_q     <= '0;
            all_q      <= 1'b0;
            idx_q      <= '0;
            entry_q    <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            rom_rd_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        prof_q <= profile_sel;
                        chan_q <= chan_all ? '0 : chan_sel;
                        all_q  <= chan_all;
                        idx_q  <= '0;
                        if (prof_bad) begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            error_q    <= 1'b0;
                            busy_q     <= 1'b1;
                            rom_rd_q   <= 1'b1;
                            rom_addr_q <= rom_ptr(profile_sel, '0);
                            state_q    <= S_ROM_REQ;
                        end
                    end
                end
                S_ROM_REQ: state_q <= S_ROM_WAIT;
                S_ROM_WAIT: begin
                    entry_q <= rom_data;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    addr_q <= {chan_q, 1'b0, entry_q[25:16]};
                    tmo_q  <= '0;
                    if (mask == 8'h00) begin
                        state_q <= S_NEXT;
                    end else if (mask == 8'hFF) begin
                        wdata_q <= value;
                        wr_q    <= 1'b1;
                        state_q <= S_AV_WR;
                    end else begin
                        rd_q    <= 1'b1;
                        state_q <= S_AV_RD;
                    end
                end
                S_AV_RD: begin
                    if (!reconfig_waitrequest) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b1;
                        wdata_q <= merge_d;
                        tmo_q   <= '0;
                        state_q <= S_AV_WR;
                    end else if (tmo_hit) begin
                        rd_q    <= 1'b0;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_AV_WR: begin
                    if (!reconfig_waitrequest) begin
                        wr_q    <= 1'b0;
                        state_q <= S_NEXT;
                    end else if (tmo_hit) begin
                        wr_q    <= 1'b0;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    // broadcast restarts the entry walk on the following channel
                    if (idx_q < LAST_IDX) begin
                        idx_q      <= idx_d;
                        rom_rd_q   <= 1'b1;
                        rom_addr_q <= rom_ptr(prof_q, idx_d);
                        state_q    <= S_ROM_REQ;
                    end else if (all_q && (chan_q < LAST_CH)) begin
                        chan_q     <= chan_q + 1'b1;
                        idx_q      <= '0;
                        rom_rd_q   <= 1'b1;
                        rom_addr_q <= rom_ptr(prof_q, '0);
                        state_q    <= S_ROM_REQ;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign rom_rd             = rom_rd_q;
    assign rom_addr           = rom_addr_q;
    assign reconfig_address   = addr_q;
    assign reconfig_read      = rd_q;
    assign reconfig_write     = wr_q;
    assign reconfig_writedata = {24'h0, wdata_q};

endmodule

// File: tb/tb_alt_mge_phy_reconfig_rmw_seq.sv
// Bench for the RMW sequencer: ROM + Avalon slave models and a
// transaction-level reference of the profile walk.
module tb_alt_mge_phy_reconfig_rmw_seq;

    localparam int NCH = 4;
    localparam int NPR = 3;
    localparam int DEP = 7;
    localparam int TMO = 16;
    localparam int CHW = 2;
    localparam int PW  = 2;
    localparam int RAW = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [PW-1:0]   profile_sel = '0;
    logic [CHW-1:0]  chan_sel = '0;
    logic            chan_all = 1'b0;
    logic            busy, done, error, rom_rd;
    logic [RAW-1:0]  rom_addr;
    logic [25:0]     rom_data = '0;
    logic [CHW+10:0] reconfig_address;
    logic            reconfig_read, reconfig_write;
    logic [31:0]     reconfig_writedata, reconfig_readdata;
    logic            reconfig_waitrequest;

    logic [25:0] rom [0:31];
    logic [7:0]  smem [0:8191];
    logic [7:0]  mm [0:8191];

    logic [63:0] txq[$], exp_log[$];
    int          rom_q[$], exp_rom[$];
    int          exp_busy;
    int          total = 0, bad = 0;
    int          both_cnt = 0, rd_run = 0, max_rd_run = 0;
    bit          rand_en = 0, rand_wait = 0, stuck_en = 0;
    int          stall_run = 0;
    logic [9:0]  stuck_addr = '0;
    int          glitch_at = -1;
    logic [PW-1:0]  g_prof = '0;
    logic [CHW-1:0] g_ch = '0;
    logic           g_all = 1'b0;

    always #5 clk = ~clk;

    alt_mge_phy_reconfig_rmw_seq #(
        .NUM_CHANNELS(NCH), .NUM_PROFILES(NPR), .RAM_DEPTH(DEP),
        .CH_W(CHW), .PROF_W(PW), .ROM_AW(RAW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .profile_sel(profile_sel), .chan_sel(chan_sel), .chan_all(chan_all),
        .busy(busy), .done(done), .error(error),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .reconfig_address(reconfig_address),
        .reconfig_read(reconfig_read), .reconfig_write(reconfig_write),
        .reconfig_writedata(reconfig_writedata),
        .reconfig_readdata(reconfig_readdata),
        .reconfig_waitrequest(reconfig_waitrequest)
    );

    function automatic logic [63:0] txn(input int kind, input int addr, input logic [31:0] d);
        return {8'(kind), 24'(addr), d};
    endfunction

    assign reconfig_readdata = {24'h0, smem[reconfig_address]};
    assign reconfig_waitrequest = rand_wait |
        (stuck_en && reconfig_read && reconfig_address[9:0] == stuck_addr);

    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    always @(negedge clk) begin
        if (rand_en && stall_run < 3 && $urandom_range(0, 3) == 0) begin
            rand_wait = 1'b1;
            stall_run++;
        end else begin
            rand_wait = 1'b0;
            stall_run = 0;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (reconfig_read && reconfig_write) both_cnt++;
            if (reconfig_read) rd_run++; else rd_run = 0;
            if (rd_run > max_rd_run) max_rd_run = rd_run;
            if (reconfig_read && !reconfig_waitrequest)
                txq.push_back(txn(1, int'(reconfig_address), 32'h0));
            if (reconfig_write && !reconfig_waitrequest) begin
                txq.push_back(txn(2, int'(reconfig_address), reconfig_writedata));
                smem[reconfig_address] = reconfig_writedata[7:0];
            end
            if (rom_rd) rom_q.push_back(int'(rom_addr));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk channels and entries straight from the ROM image,
    // applying the mask merge to a private copy of the slave memory.
    task automatic model(input int p, input int c, input bit a, input int abort_idx);
        int first, last, n, addr;
        logic [25:0] ent;
        logic [7:0] m, v, nv;
        exp_log.delete();
        exp_rom.delete();
        exp_busy = 0;
        n = 0;
        for (int k = 0; k < 8192; k++) mm[k] = smem[k];
        first = a ? 0 : c;
        last  = a ? NCH - 1 : c;
        for (int ch = first; ch <= last; ch++) begin
            for (int e = 0; e < DEP; e++) begin
                exp_rom.push_back(p * DEP + e);
                if (n == abort_idx) return;
                n++;
                ent  = rom[p * DEP + e];
                addr = ch * 2048 + int'(ent[25:16]);
                m = ent[15:8];
                v = ent[7:0];
                if (m == 8'h00) begin
                    exp_busy += 4;
                end else if (m == 8'hFF) begin
                    exp_log.push_back(txn(2, addr, {24'h0, v}));
                    mm[addr] = v;
                    exp_busy += 5;
                end else begin
                    nv = (mm[addr] & ~m) | (v & m);
                    exp_log.push_back(txn(1, addr, 32'h0));
                    exp_log.push_back(txn(2, addr, {24'h0, nv}));
                    mm[addr] = nv;
                    exp_busy += 6;
                end
            end
        end
    endtask

    task automatic fill_rom(input int p, input int mode);
        int k;
        logic [7:0] m;
        for (int e = 0; e < DEP; e++) begin
            k = (mode == 0) ? int'($urandom_range(0, 3)) : (mode == 1 ? 1 : 2);
            m = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom_range(1, 254));
            rom[p * DEP + e] = {10'(p * 64 + e * 8 + $urandom_range(0, 7)), m, 8'($urandom)};
        end
    endtask

    task automatic compare_logs(input string tag);
        check({tag, " txn_count"}, 64'(txq.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++)
            if (i < txq.size()) check($sformatf("%s txn%0d", tag, i), txq[i], exp_log[i]);
        check({tag, " rom_count"}, 64'(rom_q.size()), 64'(exp_rom.size()));
        for (int i = 0; i < exp_rom.size(); i++)
            if (i < rom_q.size()) check($sformatf("%s rom%0d", tag, i), 64'(rom_q[i]), 64'(exp_rom[i]));
    endtask

    task automatic run(input int p, input int c, input bit a, output int bc, output bit to);
        txq.delete();
        rom_q.delete();
        max_rd_run = 0;
        @(negedge clk);
        profile_sel = PW'(p);
        chan_sel = CHW'(c);
        chan_all = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bc = 0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            if (busy) bc++;
            if (i == glitch_at) begin
                start = 1'b1;
                profile_sel = g_prof;
                chan_sel = g_ch;
                chan_all = g_all;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_seen", 64'(to), 64'(0));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int count_kind(input int kind);
        int n = 0;
        foreach (txq[i]) if (int'(txq[i][63:56]) == kind) n++;
        return n;
    endfunction

    initial begin
        int  bc;
        bit  to;
        int  p, c;
        bit  a;
        bit  seen;
        for (int k = 0; k < 8192; k++) smem[k] = 8'($urandom);
        for (int k = 0; k < 32; k++) rom[k] = '0;
        for (int k = 0; k < NPR; k++) fill_rom(k, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst error", 64'(error), 64'(0));
        check("rst rom_rd", 64'(rom_rd), 64'(0));
        check("rst read", 64'(reconfig_read), 64'(0));
        check("rst write", 64'(reconfig_write), 64'(0));
        check("rst wdata", 64'(reconfig_writedata), 64'(0));
        check("rst addr", 64'(reconfig_address), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // single partial-mask entry, remaining entries inert
        rom[0] = {10'h135, 8'h4F, 8'h42};
        for (int e = 1; e < DEP; e++) rom[e] = {10'(10'h200 + e * 8), 8'h00, 8'h00};
        smem[13'h1135] = 8'hB5;
        model(0, 2, 0, -1);
        run(0, 2, 0, bc, to);
        check("t1 error", 64'(error), 64'(0));
        check("t1 ntx", 64'(txq.size()), 64'(2));
        if (txq.size() == 2) begin
            check("t1 read", txq[0], txn(1, 32'h1135, 32'h0));
            check("t1 write", txq[1], txn(2, 32'h1135, 32'hF2));
        end
        check("t1 busy", 64'(bc), 64'(exp_busy));
        compare_logs("t1");

        // all-FF profile: write only, 5 cycles per entry
        fill_rom(1, 1);
        model(1, 1, 0, -1);
        run(1, 1, 0, bc, to);
        check("t2 reads", 64'(count_kind(1)), 64'(0));
        check("t2 writes", 64'(count_kind(2)), 64'(DEP));
        check("t2 busy", 64'(bc), 64'(5 * DEP));
        compare_logs("t2");

        // broadcast, all partial masks, random stalls
        fill_rom(2, 2);
        rand_en = 1;
        model(2, 0, 1, -1);
        run(2, 0, 1, bc, to);
        rand_en = 0;
        check("t3 reads", 64'(count_kind(1)), 64'(NCH * DEP));
        check("t3 writes", 64'(count_kind(2)), 64'(NCH * DEP));
        check("t3 error", 64'(error), 64'(0));
        compare_logs("t3");

        // read of entry 3 stalls forever
        fill_rom(0, 2);
        stuck_addr = rom[3][25:16];
        stuck_en = 1;
        model(0, 1, 0, 3);
        run(0, 1, 0, bc, to);
        stuck_en = 0;
        check("t4 error", 64'(error), 64'(1));
        check("t4 read_len", 64'(max_rd_run), 64'(TMO));
        compare_logs("t4");
        fill_rom(1, 0);
        model(1, 0, 0, -1);
        run(1, 0, 0, bc, to);
        check("t4 err_clr", 64'(error), 64'(0));
        compare_logs("t4b");

        // start while busy is ignored
        fill_rom(2, 0);
        model(2, 3, 0, -1);
        glitch_at = 6;
        g_prof = 2'd0;
        g_ch = 2'd1;
        g_all = 1'b1;
        run(2, 3, 0, bc, to);
        glitch_at = -1;
        check("t5 busy", 64'(bc), 64'(exp_busy));
        compare_logs("t5");

        // reset during a write
        fill_rom(1, 1);
        @(negedge clk);
        profile_sel = 2'd1;
        chan_sel = 2'd2;
        chan_all = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (reconfig_write) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t6 write_seen", 64'(seen), 64'(1));
        reset = 1'b1;
        #1;
        check("t6 write", 64'(reconfig_write), 64'(0));
        check("t6 busy", 64'(busy), 64'(0));
        check("t6 done", 64'(done), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("t6 no_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        model(1, 2, 0, -1);
        run(1, 2, 0, bc, to);
        check("t6 busy_full", 64'(bc), 64'(exp_busy));
        compare_logs("t6");

        // out-of-range profile
        run(3, 0, 0, bc, to);
        check("t7 error", 64'(error), 64'(1));
        check("t7 busy", 64'(bc), 64'(0));
        check("t7 ntx", 64'(txq.size()), 64'(0));
        check("t7 nrom", 64'(rom_q.size()), 64'(0));

        rand_en = 1;
        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(0, NPR - 1));
            c = int'($urandom_range(0, NCH - 1));
            a = 1'($urandom_range(0, 1));
            fill_rom(p, 0);
            model(p, c, a, -1);
            run(p, c, a, bc, to);
            check($sformatf("rnd%0d error", r), 64'(error), 64'(0));
            compare_logs($sformatf("rnd%0d", r));
        end
        rand_en = 0;

        check("rd_wr_overlap", 64'(both_cnt), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
